// File: rtl/bus_hold_arbiter.sv
// Bus hold arbiter: CPU/DMA hold-acknowledge handshake, owner address mux and per-channel page registers.
// Optional rotating priority is enabled by defining BUS_ARBITER_ROTATE_PRIORITY_EN.
module bus_hold_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int ADDRESS_WIDTH = 20,
    parameter int PAGE_WIDTH    = 4,
    parameter int SELECT_WIDTH  = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [2:0]                        processor_status,
    input  logic                              processor_lock_n,
    input  logic [NUM_MASTERS-1:0]            hold_request,
    output logic                              hold_acknowledge,
    output logic [NUM_MASTERS-1:0]            dma_acknowledge_n,
    output logic [SELECT_WIDTH-1:0]           bus_owner,
    output logic                              address_enable_n,
    output logic                              dma_wait_n,
    input  logic [ADDRESS_WIDTH-1:0]          cpu_address,
    input  logic [ADDRESS_WIDTH-PAGE_WIDTH-1:0] master_address,
    input  logic [ADDRESS_WIDTH-1:0]          address_ext,
    output logic [ADDRESS_WIDTH-1:0]          address,
    output logic                              address_direction,
    input  logic                              page_chip_select_n,
    input  logic                              io_write_n,
    input  logic [SELECT_WIDTH-1:0]           page_select,
    input  logic [PAGE_WIDTH-1:0]             page_data_in
);

    typedef enum logic [2:0] {IDLE, SYNC, FLOAT, OWNED, RELEASE} state_t;

    state_t                  state;
    logic [PAGE_WIDTH-1:0]   page [NUM_MASTERS];
    logic                    any_request;
    logic                    cpu_passive;
    logic                    owner_request;
    logic [PAGE_WIDTH-1:0]   owner_page;
    logic [SELECT_WIDTH-1:0] winner;
    logic                    page_write;
    logic                    unused_status;

    assign any_request   = |hold_request;
    assign cpu_passive   = (processor_status[1:0] == 2'b11);
    assign page_write    = !page_chip_select_n && !io_write_n;
    assign unused_status = processor_status[2];

    always_comb begin
        owner_request = 1'b0;
        owner_page    = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (bus_owner == SELECT_WIDTH'(i)) begin
                owner_request = hold_request[i];
                owner_page    = page[i];
            end
        end
    end

`ifdef BUS_ARBITER_ROTATE_PRIORITY_EN
    logic [SELECT_WIDTH-1:0]    pointer;
    logic [2*NUM_MASTERS-1:0]   doubled;
    logic [NUM_MASTERS-1:0]     rotated;

    // Requests rotated so that bit 0 is the pointer's channel; winner maps back modulo NUM_MASTERS.
    assign doubled = {hold_request, hold_request} >> pointer;
    assign rotated = doubled[NUM_MASTERS-1:0];

    always_comb begin
        int unsigned slot;
        slot   = 0;
        winner = '0;
        for (int unsigned i = NUM_MASTERS; i > 0; i--) begin
            if (rotated[i-1]) begin
                slot = int'(pointer) + i - 1;
                if (slot >= NUM_MASTERS) begin
                    slot = slot - NUM_MASTERS;
                end
                winner = SELECT_WIDTH'(slot);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int unsigned i = NUM_MASTERS; i > 0; i--) begin
            if (hold_request[i-1]) begin
                winner = SELECT_WIDTH'(i - 1);
            end
        end
    end
`endif

    // Outputs are loaded together with the state transition so they always match the new state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            hold_acknowledge  <= 1'b0;
            dma_acknowledge_n <= '1;
            bus_owner         <= '0;
            address_enable_n  <= 1'b0;
            dma_wait_n        <= 1'b1;
`ifdef BUS_ARBITER_ROTATE_PRIORITY_EN
            pointer           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_request && cpu_passive && processor_lock_n) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (any_request) begin
                        state            <= FLOAT;
                        bus_owner        <= winner;
                        address_enable_n <= 1'b1;
                        dma_wait_n       <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                FLOAT: begin
                    state            <= OWNED;
                    hold_acknowledge <= 1'b1;
                    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                        dma_acknowledge_n[i] <= (bus_owner != SELECT_WIDTH'(i));
                    end
                end
                OWNED: begin
                    if (!owner_request) begin
                        state             <= RELEASE;
                        hold_acknowledge  <= 1'b0;
                        dma_acknowledge_n <= '1;
                    end
                end
                RELEASE: begin
                    state            <= IDLE;
                    bus_owner        <= '0;
                    address_enable_n <= 1'b0;
                    dma_wait_n       <= 1'b1;
`ifdef BUS_ARBITER_ROTATE_PRIORITY_EN
                    if (int'(bus_owner) >= NUM_MASTERS - 1) begin
                        pointer <= '0;
                    end else begin
                        pointer <= bus_owner + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                page[i] <= '0;
            end
        end else if (page_write) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (page_select == SELECT_WIDTH'(i)) begin
                    page[i] <= page_data_in;
                end
            end
        end
    end

    always_comb begin
        address           = cpu_address;
        address_direction = 1'b0;
        case (state)
            OWNED: begin
                address = {owner_page, master_address};
            end
            FLOAT, RELEASE: begin
                address           = address_ext;
                address_direction = 1'b1;
            end
            default: begin
                address           = cpu_address;
                address_direction = 1'b0;
            end
        endcase
    end

endmodule
